// File: rtl/axis_variant_multi.sv
// axis_variant_multi: watches CHANNELS configuration words and reports each changed word as an AXI-Stream transfer
//
// Optional feature: define AXIS_VARIANT_MULTI_REFRESH_EN to add a periodic refresh that re-reports every channel.
//
// Ports:
//   aclk          - clock, rising edge
//   aresetn       - synchronous active-low reset
//   cfg_data      - CHANNELS packed words, channel i at [i*W +: W]
//   cfg_period    - refresh period in cycles, 0 disables refresh (REFRESH_EN builds only)
//   m_axis_tready - downstream ready
//   m_axis_tdata  - value of the reported channel
//   m_axis_tdest  - index of the reported channel
//   m_axis_tvalid - output word valid
module axis_variant_multi #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CHANNELS         = 4,
   parameter int DEST_WIDTH       = 2
`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
  ,parameter int CNTR_WIDTH       = 32
`endif
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] cfg_data,
`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
   input  logic [CNTR_WIDTH-1:0]                cfg_period,
`endif
   input  logic                                 m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0]          m_axis_tdata,
   output logic [DEST_WIDTH-1:0]                m_axis_tdest,
   output logic                                 m_axis_tvalid
);
   localparam int W = AXIS_TDATA_WIDTH;

   logic [W-1:0]          snap [CHANNELS];
   logic [CHANNELS-1:0]   pend;
   logic [CHANNELS-1:0]   changed;
   logic [CHANNELS-1:0]   refresh;
   logic [CHANNELS-1:0]   clear_mask;
   logic [DEST_WIDTH-1:0] last_grant;
   logic [DEST_WIDTH-1:0] grant;
   logic [DEST_WIDTH-1:0] grant_hi;
   logic [DEST_WIDTH-1:0] grant_lo;
   logic                  found_hi;
   logic                  load;
   logic [W-1:0]          grant_data;

   always_comb begin
      changed = '0;
      for (int i = 0; i < CHANNELS; i++)
         changed[i] = cfg_data[i*W +: W] != snap[i];
   end

   // Round robin: lowest pending index above last_grant, otherwise wrap to the lowest pending index.
   always_comb begin
      grant_hi = '0;
      grant_lo = '0;
      found_hi = 1'b0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (pend[i]) begin
            grant_lo = DEST_WIDTH'(i);
            if (i > int'(last_grant)) begin
               grant_hi = DEST_WIDTH'(i);
               found_hi = 1'b1;
            end
         end
      end
      grant = found_hi ? grant_hi : grant_lo;
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < CHANNELS; i++)
         if (grant == DEST_WIDTH'(i))
            grant_data = cfg_data[i*W +: W];
   end

   assign load       = (|pend) && (!m_axis_tvalid || m_axis_tready);
   assign clear_mask = load ? (CHANNELS'(1) << grant) : '0;

`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
   logic [CNTR_WIDTH-1:0] cnt;
   logic                  wrap;

   // >= keeps the counter bounded if cfg_period shrinks below the current count.
   assign wrap    = (cfg_period != '0) && (cnt >= cfg_period - 1'b1);
   assign refresh = {CHANNELS{wrap}};

   always_ff @(posedge aclk) begin
      if (!aresetn || cfg_period == '0)
         cnt <= '0;
      else
         cnt <= wrap ? '0 : cnt + 1'b1;
   end
`else
   assign refresh = '0;
`endif

   // Sets are ORed in after the clear so a channel changing while being loaded is reported again.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < CHANNELS; i++)
            snap[i] <= '0;
         pend          <= '0;
         m_axis_tdata  <= '0;
         m_axis_tdest  <= '0;
         m_axis_tvalid <= 1'b0;
         last_grant    <= DEST_WIDTH'(CHANNELS - 1);
      end else begin
         for (int i = 0; i < CHANNELS; i++)
            snap[i] <= cfg_data[i*W +: W];
         pend <= (pend & ~clear_mask) | changed | refresh;
         if (load) begin
            m_axis_tdata  <= grant_data;
            m_axis_tdest  <= grant;
            m_axis_tvalid <= 1'b1;
            last_grant    <= grant;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axis_variant_multi.sv
// tb_axis_variant_multi: directed scenarios plus randomized traffic checked against a reference model
module tb_axis_variant_multi;
   localparam int CH = 4;
   localparam int W  = 32;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic [CH*W-1:0] cfg_data;
   logic            m_axis_tready;
   logic [W-1:0]    m_axis_tdata;
   logic [1:0]      m_axis_tdest;
   logic            m_axis_tvalid;
`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
   logic [31:0]     cfg_period;
`endif

   int n_checks = 0;
   int n_errors = 0;

   axis_variant_multi #(
      .AXIS_TDATA_WIDTH(W),
      .CHANNELS(CH),
      .DEST_WIDTH(2)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .cfg_data(cfg_data),
`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
      .cfg_period(cfg_period),
`endif
      .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tdest(m_axis_tdest),
      .m_axis_tvalid(m_axis_tvalid)
   );

   always #5 aclk = ~aclk;

   // Reference model: per-channel last seen value and pending flag, one output slot, round-robin pointer.
   logic [W-1:0] m_seen [CH];
   bit           m_pend [CH];
   int           m_last;
   bit           m_valid;
   logic [W-1:0] m_data;
   int           m_dest;
`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
   int           m_cnt;
`endif

   always @(posedge aclk) begin
      bit ld;
      int g;
      int j;
      bit chg [CH];
      if (!aresetn) begin
         for (int i = 0; i < CH; i++) begin
            m_seen[i] = '0;
            m_pend[i] = 0;
         end
         m_last  = CH - 1;
         m_valid = 0;
         m_data  = '0;
         m_dest  = 0;
`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
         m_cnt   = 0;
`endif
      end else begin
         ld = 0;
         g  = 0;
         if (!m_valid || m_axis_tready)
            for (int k = 1; k <= CH; k++) begin
               j = (m_last + k) % CH;
               if (!ld && m_pend[j]) begin
                  ld = 1;
                  g  = j;
               end
            end
         for (int i = 0; i < CH; i++)
            chg[i] = cfg_data[i*W +: W] != m_seen[i];
         if (ld) begin
            m_data    = cfg_data[g*W +: W];
            m_dest    = g;
            m_valid   = 1;
            m_last    = g;
            m_pend[g] = 0;
         end else if (m_axis_tready) begin
            m_valid = 0;
         end
         for (int i = 0; i < CH; i++) begin
            if (chg[i])
               m_pend[i] = 1;
            m_seen[i] = cfg_data[i*W +: W];
         end
`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
         if (cfg_period == 0) begin
            m_cnt = 0;
         end else if (m_cnt == int'(cfg_period) - 1) begin
            m_cnt = 0;
            for (int i = 0; i < CH; i++)
               m_pend[i] = 1;
         end else begin
            m_cnt++;
         end
`endif
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      @(negedge aclk);
      check("model_tvalid", 64'(m_axis_tvalid), 64'(m_valid));
      if (m_valid) begin
         check("model_tdata", 64'(m_axis_tdata), 64'(m_data));
         check("model_tdest", 64'(m_axis_tdest), 64'(m_dest));
      end
   endtask

   task automatic set_ch(input int i, input logic [W-1:0] v);
      cfg_data[i*W +: W] = v;
   endtask

   task automatic expect_word(input string tag, input int dest, input logic [W-1:0] data);
      check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd1);
      check({tag, "_tdest"}, 64'(m_axis_tdest), 64'(dest));
      check({tag, "_tdata"}, 64'(m_axis_tdata), 64'(data));
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      tick();
      check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("reset_tdata", 64'(m_axis_tdata), 64'd0);
      tick();
      aresetn = 1'b1;
   endtask

   initial begin
      aresetn       = 1'b0;
      cfg_data      = '0;
      m_axis_tready = 1'b1;
`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
      cfg_period    = 0;
`endif
      do_reset();

      repeat (20) begin
         tick();
         check("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
      end

      set_ch(2, 32'h1234);
      tick();
      check("single_edge1_tvalid", 64'(m_axis_tvalid), 64'd0);
      tick();
      expect_word("single", 2, 32'h1234);
      tick();
      check("single_done_tvalid", 64'(m_axis_tvalid), 64'd0);

      cfg_data = '0;
      do_reset();
      set_ch(0, 32'hA);
      set_ch(1, 32'hB);
      set_ch(3, 32'hC);
      tick();
      check("multi_edge1_tvalid", 64'(m_axis_tvalid), 64'd0);
      tick();
      expect_word("multi0", 0, 32'hA);
      tick();
      expect_word("multi1", 1, 32'hB);
      tick();
      expect_word("multi3", 3, 32'hC);
      tick();
      check("multi_done_tvalid", 64'(m_axis_tvalid), 64'd0);

      m_axis_tready = 1'b0;
      set_ch(1, 32'd5);
      tick();
      tick();
      expect_word("coal_load5", 1, 32'd5);
      set_ch(1, 32'd6);
      tick();
      expect_word("coal_hold6", 1, 32'd5);
      set_ch(1, 32'd7);
      tick();
      expect_word("coal_hold7", 1, 32'd5);
      m_axis_tready = 1'b1;
      tick();
      expect_word("coal_out7", 1, 32'd7);
      tick();
      check("coal_done_tvalid", 64'(m_axis_tvalid), 64'd0);

      set_ch(0, 32'h100);
      tick();
      set_ch(0, 32'h200);
      tick();
      expect_word("repend_first", 0, 32'h200);
      tick();
      expect_word("repend_second", 0, 32'h200);
      tick();
      check("repend_done_tvalid", 64'(m_axis_tvalid), 64'd0);

      aresetn  = 1'b0;
      cfg_data = '0;
      set_ch(0, 32'd1);
      set_ch(2, 32'd2);
      tick();
      tick();
      aresetn = 1'b1;
      tick();
      check("post_reset_edge1", 64'(m_axis_tvalid), 64'd0);
      tick();
      expect_word("post_reset0", 0, 32'd1);
      tick();
      expect_word("post_reset2", 2, 32'd2);
      tick();
      check("post_reset_done", 64'(m_axis_tvalid), 64'd0);

      m_axis_tready = 1'b0;
      set_ch(3, 32'h55);
      tick();
      tick();
      expect_word("midxfer_held", 3, 32'h55);
      aresetn = 1'b0;
      tick();
      check("midxfer_drop_tvalid", 64'(m_axis_tvalid), 64'd0);
      aresetn       = 1'b1;
      m_axis_tready = 1'b1;

`ifdef AXIS_VARIANT_MULTI_REFRESH_EN
      cfg_period = 100;
`endif
      repeat (800) begin
         m_axis_tready = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 3) == 0)
            set_ch(int'($urandom_range(0, CH - 1)), W'($urandom_range(0, 3)));
         aresetn = $urandom_range(0, 199) != 0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
